// File: rtl/norm_pkg.sv
// Shared types and helpers for the iterative leading-one normaliser.
package norm_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Exponent arithmetic runs at a fixed wide width; callers keep the low EXP_WIDTH bits.
  localparam int unsigned MaxExpW = 64;

  typedef struct packed {
    logic               ovfl;
    logic [MaxExpW-1:0] val;
  } exp_res_t;

  // Width of the shift counter; it must hold SRCH_WIND-1.
  function automatic int unsigned cnt_width(int unsigned srch_wind);
    return (srch_wind < 2) ? 1 : $clog2(srch_wind);
  endfunction

  // base +/- delta, both already zero-extended from `width` bits.
  // Bit `width` of the wide result is the carry (add) or the borrow (subtract).
  function automatic exp_res_t exp_adjust(logic [MaxExpW-1:0] base, logic [MaxExpW-1:0] delta,
                                          logic sub, int unsigned width);
    logic [MaxExpW:0] r;
    exp_res_t         res;
    r = sub ? ({1'b0, base} - {1'b0, delta}) : ({1'b0, base} + {1'b0, delta});
    res.ovfl = r[width];
    res.val  = r[MaxExpW-1:0];
    return res;
  endfunction

endpackage

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter over STEP bits; returns STEP when all bits are zero.
module norm_lzc #(
  parameter int unsigned STEP = 4,
  localparam int unsigned Z_W = $clog2(STEP + 1)
) (
  input  logic [STEP-1:0] bits,
  output logic [Z_W-1:0]  zeros
);

  // Ascending scan: the highest set bit is the last one to write.
  always_comb begin
    zeros = Z_W'(STEP);
    for (int i = 0; i < STEP; i++) begin
      if (bits[i]) zeros = Z_W'(STEP - 1 - i);
    end
  end

endmodule

// File: rtl/norm_seq.sv
// Iterative leading-one normaliser: shifts up to STEP bits per clock within a SRCH_WIND window.
module norm_seq
  import norm_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 32,
  parameter int unsigned SRCH_WIND = 32,
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned EXP_CTR   = 0,
  parameter int unsigned STEP      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [EXP_WIDTH-1:0] in_exp_offset,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_WIDTH-1:0]   out_b,
  output logic [EXP_WIDTH-1:0] out_exp_adj,
  output logic                 out_no_detect,
  output logic                 out_ovfl,
  output logic                 busy
);

  localparam int unsigned CNT_W = cnt_width(SRCH_WIND);
  localparam int unsigned Z_W   = $clog2(STEP + 1);
  localparam logic [CNT_W-1:0] MaxShift = CNT_W'(SRCH_WIND - 1);

  state_e               state_q;
  logic [A_WIDTH-1:0]   w_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [EXP_WIDTH-1:0] off_q;
  logic                 out_valid_q;
  logic [A_WIDTH-1:0]   out_b_q;
  logic [EXP_WIDTH-1:0] out_exp_adj_q;
  logic                 out_no_detect_q;
  logic                 out_ovfl_q;

  logic [Z_W-1:0]       z;
  logic [CNT_W-1:0]     z_ext;
  logic [CNT_W-1:0]     rem;
  logic [CNT_W-1:0]     s;
  logic [A_WIDTH-1:0]   w_nxt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 shift_done;
  exp_res_t             exp_res;
  logic                 unused_exp;

  norm_lzc #(
    .STEP (STEP)
  ) u_lzc (
    .bits  (w_q[A_WIDTH-1 -: STEP]),
    .zeros (z)
  );

  always_comb begin
    z_ext      = CNT_W'(z);
    rem        = MaxShift - cnt_q;
    s          = (z_ext < rem) ? z_ext : rem;
    w_nxt      = w_q << s;
    cnt_nxt    = cnt_q + s;
    // A one inside the inspected slice, or the window exhausted, ends the search.
    shift_done = (z != Z_W'(STEP)) || (s == rem);
    exp_res    = exp_adjust(MaxExpW'(off_q), MaxExpW'(cnt_nxt), EXP_CTR != 0, EXP_WIDTH);
    unused_exp = ^exp_res.val[MaxExpW-1:EXP_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      w_q             <= '0;
      cnt_q           <= '0;
      off_q           <= '0;
      out_valid_q     <= 1'b0;
      out_b_q         <= '0;
      out_exp_adj_q   <= '0;
      out_no_detect_q <= 1'b0;
      out_ovfl_q      <= 1'b0;
    end else if (clr) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            w_q     <= in_a;
            cnt_q   <= '0;
            off_q   <= in_exp_offset;
            state_q <= StShift;
          end
        end
        StShift: begin
          w_q   <= w_nxt;
          cnt_q <= cnt_nxt;
          if (shift_done) begin
            state_q         <= StDone;
            out_valid_q     <= 1'b1;
            out_b_q         <= w_nxt;
            out_no_detect_q <= ~w_nxt[A_WIDTH-1];
            out_exp_adj_q   <= exp_res.val[EXP_WIDTH-1:0];
            out_ovfl_q      <= exp_res.ovfl;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            // Back-to-back accept: no idle bubble between results.
            if (in_valid) begin
              w_q     <= in_a;
              cnt_q   <= '0;
              off_q   <= in_exp_offset;
              state_q <= StShift;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready      = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid     = out_valid_q;
  assign out_b         = out_b_q;
  assign out_exp_adj   = out_exp_adj_q;
  assign out_no_detect = out_no_detect_q;
  assign out_ovfl      = out_ovfl_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: doc/norm_seq.md
# norm_seq

Iterative, parametrised leading-one normaliser with valid/ready handshakes on both sides. It left-shifts an operand until its MSB is 1, searching at most SRCH_WIND bit positions and shifting up to STEP bits per clock. It also returns the adjusted exponent, overflow and no-detect flags. It is the multi-cycle successor to the combinational normaliser, used in floating-point datapaths where area matters more than latency.

## Interface
- A_WIDTH, 32: operand width.
- SRCH_WIND, 32: search window in bits, legal range 2..A_WIDTH. Maximum total shift is SRCH_WIND-1.
- EXP_WIDTH, 8: exponent width. Must satisfy EXP_WIDTH >= clog2(SRCH_WIND).
- EXP_CTR, 0: exponent direction. 0 means exp_offset + shift; 1 means exp_offset - shift.
- STEP, 4: maximum shift per cycle, legal range 1..SRCH_WIND-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort; forces IDLE and drops any in-flight operation.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_a  in  A_WIDTH  operand.
- in_exp_offset  in  EXP_WIDTH  exponent base.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_b  out  A_WIDTH  normalised operand.
- out_exp_adj  out  EXP_WIDTH  adjusted exponent.
- out_no_detect  out  1  no 1 found in the top SRCH_WIND bits.
- out_ovfl  out  1  exponent wrapped.
- busy  out  1  state is not IDLE.

## Operation
- Registers: working operand w, shift count cnt (clog2(SRCH_WIND) bits), offset register, and registered outputs.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: load w = in_a, cnt = 0, capture in_exp_offset, go to SHIFT.
- SHIFT:
  - rem = SRCH_WIND-1-cnt.
  - z = number of leading zeros of w's top STEP bits, in the range 0..STEP.
  - s = min(z, rem). Update w <<= s, cnt += s.
  - If z < STEP or s == rem, go to DONE and register the outputs. Otherwise stay in SHIFT.
- Results:
  - out_b = final w.
  - out_no_detect = ~final w[A_WIDTH-1].
  - out_exp_adj = (offset ± cnt) mod 2^EXP_WIDTH.
  - out_ovfl = carry-out of the add (EXP_CTR=0) or borrow of the subtract (EXP_CTR=1).
- DONE:
  - out_valid = 1; all outputs held stable until out_ready.
  - On out_ready, go to IDLE.
  - in_ready = out_ready. If in_valid is also high, the new operand loads and the state goes straight to SHIFT (no idle bubble).
- clr has priority over every transition. It sets state to IDLE and clears out_valid. Data registers need not clear.
- Zero operand: cnt = SRCH_WIND-1, out_b = 0, out_no_detect = 1.
- Operand already normalised (MSB = 1): one SHIFT cycle with s = 0.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, out_b 0, out_exp_adj 0, out_no_detect 0, out_ovfl 0.
- Let t be the final shift and W = SRCH_WIND-1.
- Number of SHIFT cycles N = min(floor(t/STEP)+1, ceil(W/STEP)).
- out_valid rises N clocks after the accepting edge.
- Peak throughput is one result per N+1 clocks when out_ready is held high.
- in_ready and out_valid are never both high except in DONE.
- in_ready is combinational on out_ready; no other combinational input-to-output path exists.
- Asynchronous reset in any state returns to IDLE immediately. A new operand is accepted on the first edge after release.

## Structure
- Package norm_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - the localparam CNT_W = clog2(SRCH_WIND);
  - a helper for the exponent add/subtract with carry/borrow.
- Sub-module norm_lzc (parameter STEP): a combinational leading-zero counter over STEP bits, returning 0..STEP. It is instantiated once.

## Test plan
All scenarios use A_WIDTH=8, SRCH_WIND=8, EXP_WIDTH=4, STEP=2 unless stated.

1. EXP_CTR=0, a=0x10, offset=3: out_b=0x80, out_exp_adj=6, no_detect=0, ovfl=0; out_valid 2 clocks after accept.
2. a=0x00, offset=3: out_b=0x00, out_exp_adj=0xA, no_detect=1, ovfl=0; N=4.
3. Overflow/underflow:
   - EXP_CTR=0, a=0x01, offset=0xE: out_b=0x80, out_exp_adj=5, ovfl=1.
   - EXP_CTR=1, a=0x10, offset=2: out_exp_adj=0xF, ovfl=1.
   - EXP_CTR=1, a=0x20, offset=2: out_exp_adj=0, ovfl=0.
4. a=0x80, offset=7: out_b=0x80, out_exp_adj=7; N=1.
5. Back-pressure:
   - Hold out_ready=0 for 5 clocks: outputs stable, in_ready=0.
   - Then out_ready=1 with in_valid=1, a=0x40: second operand accepted on the same edge, result 0x80, exp offset+1 after N=1.
6. Abort and reset:
   - Pulse clr during SHIFT of a=0x01: IDLE next clock, out_valid never asserts.
   - Drop rst_n mid-SHIFT: all outputs return to reset values immediately.
